// File: rtl/pwm_pkg.sv
// Shared definitions for the dead-time PWM generator: default widths and
// the per-leg state encoding used by pwm_leg.
package pwm_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int DT_BITS_DEF = 8;

  typedef enum logic [2:0] {
    LEG_OFF,
    LEG_LO,
    LEG_DEAD_R,
    LEG_HI,
    LEG_DEAD_F
  } leg_state_e;

endpackage

// File: rtl/pwm_leg.sv
// One half-bridge leg: registered signed compare of the active reference
// against this leg's carrier, gate FSM and dead-time down-counter.
//   i_ref_active  signed active reference (shared by all legs)
//   i_carrier     signed carrier for this leg
//   i_dead_time   dead-time cycles, sampled on entry to a DEAD state
//   i_run         1 = enabled and no latched fault; 0 forces OFF next cycle
//   o_gate_h/l    registered high/low side gates, decoded from next state
//
// state      | meaning
// LEG_OFF    | both gates off, waiting for run
// LEG_LO     | low side on
// LEG_DEAD_R | both off, rising toward HI while counter runs
// LEG_HI     | high side on
// LEG_DEAD_F | both off, falling toward LO while counter runs
module pwm_leg
  import pwm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DT_BITS = DT_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH-1:0]   i_ref_active,
  input  logic signed [WIDTH-1:0]   i_carrier,
  input  logic        [DT_BITS-1:0] i_dead_time,
  input  logic                      i_run,
  output logic                      o_gate_h,
  output logic                      o_gate_l
);

  leg_state_e         r_state;
  leg_state_e         w_state_nxt;
  logic [DT_BITS-1:0] r_cnt;
  logic [DT_BITS-1:0] w_cnt_nxt;
  logic [DT_BITS-1:0] w_dt_load;
  logic               r_cmp;
  logic               r_gate_h;
  logic               r_gate_l;

  // A zero dead time still produces one dead cycle.
  assign w_dt_load = (i_dead_time == '0) ? DT_BITS'(1) : i_dead_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp    <= 1'b0;
      r_state  <= LEG_OFF;
      r_cnt    <= '0;
      r_gate_h <= 1'b0;
      r_gate_l <= 1'b0;
    end else begin
      r_cmp    <= (i_ref_active > i_carrier);
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_gate_h <= (w_state_nxt == LEG_HI);
      r_gate_l <= (w_state_nxt == LEG_LO);
    end
  end

  // The counter is checked against 1 so that the transition out of DEAD
  // happens on the edge where it would reach 0; the dead interval is then
  // exactly w_dt_load cycles long.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_run) begin
      w_state_nxt = LEG_OFF;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        LEG_OFF: begin
          w_state_nxt = r_cmp ? LEG_DEAD_R : LEG_DEAD_F;
          w_cnt_nxt   = w_dt_load;
        end
        LEG_LO: begin
          if (r_cmp) begin
            w_state_nxt = LEG_DEAD_R;
            w_cnt_nxt   = w_dt_load;
          end
        end
        LEG_DEAD_R: begin
          if (!r_cmp) begin
            w_state_nxt = LEG_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DT_BITS'(1)) begin
            w_state_nxt = LEG_HI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - DT_BITS'(1);
          end
        end
        LEG_HI: begin
          if (!r_cmp) begin
            w_state_nxt = LEG_DEAD_F;
            w_cnt_nxt   = w_dt_load;
          end
        end
        LEG_DEAD_F: begin
          if (r_cmp) begin
            w_state_nxt = LEG_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DT_BITS'(1)) begin
            w_state_nxt = LEG_LO;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - DT_BITS'(1);
          end
        end
        default: begin
          w_state_nxt = LEG_OFF;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_gate_h = r_gate_h;
  assign o_gate_l = r_gate_l;

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Three-leg complementary PWM generator with dead time. Compares one
// double-buffered signed reference against three carriers and drives
// high/low gate pairs; a sticky fault latch forces every gate off.
//   clk, rst_n            clock, async active-low reset
//   carrier1..3           signed carriers for legs 1..3
//   ref_in, ref_load      reference value and strobe into the shadow register
//   sync                  shadow -> active reference at carrier wrap
//   dead_time             dead-time cycles
//   enable                0 = all legs OFF
//   fault, fault_clr      fault input (level) and latch clear
//   gate_h, gate_l        gates, bit i = leg i+1
//   fault_lat             sticky fault status
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DT_BITS = DT_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [WIDTH-1:0]   carrier1,
  input  logic signed [WIDTH-1:0]   carrier2,
  input  logic signed [WIDTH-1:0]   carrier3,
  input  logic signed [WIDTH-1:0]   ref_in,
  input  logic                      ref_load,
  input  logic                      sync,
  input  logic        [DT_BITS-1:0] dead_time,
  input  logic                      enable,
  input  logic                      fault,
  input  logic                      fault_clr,
  output logic        [2:0]         gate_h,
  output logic        [2:0]         gate_l,
  output logic                      fault_lat
);

  logic signed [WIDTH-1:0] r_shadow;
  logic signed [WIDTH-1:0] r_active;
  logic                    r_fault_lat;
  logic signed [WIDTH-1:0] w_carrier [3];
  logic [2:0]              w_gate_h;
  logic [2:0]              w_gate_l;
  logic                    w_run;

  // A simultaneous load and sync commits the old shadow value: both
  // registers sample their pre-edge inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_active    <= '0;
      r_fault_lat <= 1'b0;
    end else begin
      if (ref_load) r_shadow <= ref_in;
      if (sync)     r_active <= r_shadow;
      if (fault)          r_fault_lat <= 1'b1;
      else if (fault_clr) r_fault_lat <= 1'b0;
    end
  end

  assign w_run = enable & ~r_fault_lat;

  assign w_carrier[0] = carrier1;
  assign w_carrier[1] = carrier2;
  assign w_carrier[2] = carrier3;

  for (genvar g = 0; g < 3; g++) begin : g_leg
    pwm_leg #(
      .WIDTH   (WIDTH),
      .DT_BITS (DT_BITS)
    ) u_leg (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_ref_active (r_active),
      .i_carrier    (w_carrier[g]),
      .i_dead_time  (dead_time),
      .i_run        (w_run),
      .o_gate_h     (w_gate_h[g]),
      .o_gate_l     (w_gate_l[g])
    );
  end

  // The latch masks the gates directly so they drop on the same edge the
  // fault is captured, one cycle before the legs themselves reach OFF.
  assign gate_h    = w_gate_h & {3{~r_fault_lat}};
  assign gate_l    = w_gate_l & {3{~r_fault_lat}};
  assign fault_lat = r_fault_lat;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
module tb_pwm_deadtime_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] c1, c2, c3, ref_in;
  logic               ref_load, sync, enable, fault, fault_clr;
  logic [7:0]         dead_time;
  logic [2:0]         gate_h, gate_l;
  logic               fault_lat;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_deadtime_gen #(.WIDTH(16), .DT_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .carrier1  (c1),
    .carrier2  (c2),
    .carrier3  (c3),
    .ref_in    (ref_in),
    .ref_load  (ref_load),
    .sync      (sync),
    .dead_time (dead_time),
    .enable    (enable),
    .fault     (fault),
    .fault_clr (fault_clr),
    .gate_h    (gate_h),
    .gate_l    (gate_l),
    .fault_lat (fault_lat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each leg is described by the level it last settled on
  // (-1 none, 0 low, 1 high), the level it is heading toward and how many
  // dead cycles remain before it gets there.
  logic signed [15:0] m_shadow, m_active;
  logic [2:0]         m_cmp;
  logic               m_flat;
  int                 m_lvl [3];
  int                 m_dead [3];
  int                 m_toward [3];

  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_cmp = 0; m_flat = 0;
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = -1; m_dead[i] = 0; m_toward[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [2:0] ncmp;
    logic signed [15:0] car [3];
    int c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    car[0] = c1; car[1] = c2; car[2] = c3;
    for (int i = 0; i < 3; i++) ncmp[i] = (m_active > car[i]);
    for (int i = 0; i < 3; i++) begin
      c = int'(m_cmp[i]);
      if (!enable || m_flat) begin
        m_lvl[i] = -1; m_dead[i] = 0;
      end else if (m_dead[i] > 0) begin
        if (c != m_toward[i] || m_dead[i] == 1) begin
          m_lvl[i] = c; m_dead[i] = 0;
        end else begin
          m_dead[i] = m_dead[i] - 1;
        end
      end else if (m_lvl[i] != c) begin
        m_toward[i] = c;
        m_dead[i] = (dead_time == 0) ? 1 : int'(dead_time);
      end
    end
    if (fault) m_flat = 1'b1;
    else if (fault_clr) m_flat = 1'b0;
    if (sync) m_active = m_shadow;
    if (ref_load) m_shadow = ref_in;
    m_cmp = ncmp;
  endtask

  // Leg-1 dead interval measurement, active only while measure is set.
  bit measure = 0;
  bit started = 0;
  int run_len = 0;
  int exp_dt  = 5;

  task automatic tick();
    logic [2:0] eh, el;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      eh[i] = !m_flat && m_dead[i] == 0 && m_lvl[i] == 1;
      el[i] = !m_flat && m_dead[i] == 0 && m_lvl[i] == 0;
    end
    check("gate_h", gate_h, eh);
    check("gate_l", gate_l, el);
    check("fault_lat", fault_lat, m_flat);
    check("no_overlap", gate_h & gate_l, 0);
    if (measure) begin
      if (gate_h[0] | gate_l[0]) begin
        if (started && run_len > 0) check("dead_len", run_len, exp_dt);
        started = 1;
        run_len = 0;
      end else begin
        run_len++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] phase;
    int step;
    int n;
    bit seen_h;

    rst_n = 0; c1 = 0; c2 = 0; c3 = 0; ref_in = 0; ref_load = 0; sync = 0;
    dead_time = 0; enable = 0; fault = 0; fault_clr = 0;
    model_reset();

    // Reset held with toggling inputs.
    for (int k = 0; k < 10; k++) begin
      enable = 1; fault = 1'($urandom); ref_load = 1'($urandom); sync = 1'($urandom);
      ref_in = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom);
      dead_time = 8'($urandom);
      tick();
    end
    enable = 0; fault = 0; ref_load = 0; sync = 0; rst_n = 1;
    for (int k = 0; k < 10; k++) tick();
    check("reset_idle", {gate_h, gate_l}, 0);

    // Dead time 5 with ramped carriers.
    dead_time = 5; ref_in = 16'h1000; ref_load = 1; tick();
    ref_load = 0; sync = 1; tick();
    sync = 0; measure = 1; started = 0; exp_dt = 5; enable = 1;
    for (int k = 0; k < 3 * 4096; k++) begin
      c1 = 16'(k * 16); c2 = c1 + 16'sh5555; c3 = c1 + 16'shAAAA;
      tick();
    end
    measure = 0;

    // Short compare pulse aborts the rising dead interval.
    dead_time = 10; c1 = 16'h7000; c2 = 16'h7000; c3 = 16'h7000;
    for (int k = 0; k < 20; k++) tick();
    check("abort_pre_lo", gate_l, 3'b111);
    seen_h = 0;
    c1 = 16'h0000;
    for (int k = 0; k < 3; k++) begin tick(); seen_h |= gate_h[0]; end
    c1 = 16'h7000;
    for (int k = 0; k < 20; k++) begin tick(); seen_h |= gate_h[0]; end
    check("abort_no_h", seen_h, 0);
    check("abort_post_lo", gate_l, 3'b111);

    // Double buffering.
    dead_time = 2; c1 = 16'h1800; c2 = 16'h1800; c3 = 16'h1800;
    for (int k = 0; k < 5; k++) tick();
    ref_in = 16'h2000; ref_load = 1; tick();
    ref_load = 0;
    for (int k = 0; k < 10; k++) tick();
    check("dbuf_hold", gate_l, 3'b111);
    sync = 1; tick();
    sync = 0;
    for (int k = 0; k < 15; k++) tick();
    check("dbuf_commit", gate_h, 3'b111);
    ref_in = 16'h0000; ref_load = 1; sync = 1; tick();
    ref_load = 0; sync = 0;
    for (int k = 0; k < 15; k++) tick();
    check("dbuf_old_shadow", gate_h, 3'b111);
    sync = 1; tick();
    sync = 0;
    for (int k = 0; k < 15; k++) tick();
    check("dbuf_new_shadow", gate_l, 3'b111);

    // Fault handling.
    dead_time = 4; c1 = 16'hC000; c2 = 16'hC000; c3 = 16'hC000;
    for (int k = 0; k < 15; k++) tick();
    check("pre_fault_hi", gate_h, 3'b111);
    fault = 1; tick();
    fault = 0;
    check("fault_gate_h", gate_h, 0);
    check("fault_lat_set", fault_lat, 1);
    for (int k = 0; k < 5; k++) tick();
    check("fault_hold", gate_h, 0);
    fault = 1; fault_clr = 1; tick();
    fault = 0; fault_clr = 0; tick();
    check("clr_ignored", fault_lat, 1);
    fault_clr = 1; tick();
    fault_clr = 0;
    check("clr_done", fault_lat, 0);
    n = 0;
    while (gate_h == 0 && n < 50) begin tick(); n++; end
    check("reentry_delay", n, 5);

    // Extremes with zero dead time.
    dead_time = 0; ref_in = 16'h7FFF; ref_load = 1; tick();
    ref_load = 0; sync = 1; tick();
    sync = 0;
    c1 = 16'h7FFF;
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 300; k++) begin
      c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) c2 = 16'h7FFF;
      tick();
    end
    ref_in = 16'h8000; ref_load = 1; tick();
    ref_load = 0; sync = 1; tick();
    sync = 0;
    for (int k = 0; k < 20; k++) tick();
    seen_h = 0;
    for (int k = 0; k < 100; k++) begin
      c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom);
      tick();
      seen_h |= |gate_h;
    end
    check("min_ref_no_h", seen_h, 0);
    check("min_ref_lo", gate_l, 3'b111);

    // Randomized operation.
    phase = 0; step = 700;
    for (int k = 0; k < 4000; k++) begin
      enable    = ($urandom_range(0, 19) != 0);
      fault     = ($urandom_range(0, 99) == 0);
      fault_clr = ($urandom_range(0, 9) == 0);
      ref_load  = ($urandom_range(0, 7) == 0);
      sync      = ($urandom_range(0, 7) == 0);
      ref_in    = 16'($urandom);
      if ($urandom_range(0, 49) == 0) dead_time = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) step = $urandom_range(0, 3000);
      phase = phase + 16'(step);
      c1 = phase; c2 = phase + 16'h5555; c3 = phase + 16'hAAAA;
      tick();
    end

    // Asynchronous reset mid-operation.
    enable = 1; fault = 0; fault_clr = 1; ref_load = 0; sync = 0; tick();
    fault_clr = 0;
    for (int k = 0; k < 30; k++) begin
      phase = phase + 16'(step + 1);
      c1 = phase; c2 = phase + 16'h5555; c3 = phase + 16'hAAAA;
      tick();
    end
    #2 rst_n = 0;
    #1;
    check("async_h", gate_h, 0);
    check("async_l", gate_l, 0);
    check("async_flat", fault_lat, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1;
    for (int k = 0; k < 20; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
